// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a simple in-order core.  A three-state
// controller (IDLE / RUN / HALT) gates all architectural updates.  While
// running, each retiring instruction (step) moves the PC sequentially or
// redirects it by a register jump, a PC-relative unconditional jump, or a
// PC-relative conditional branch evaluated against the registered ALU flags.
// Any taken redirect captures a return address and raises taken/flush for
// the following cycle so fetch can squash its in-flight instruction.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-low reset
//   start        in   1   IDLE -> RUN request
//   halt         in   1   RUN -> HALT request
//   step         in   1   current instruction retires; PC advances
//   flag_in      in   3   ALU flags {sign, zero, carry}
//   flag_we      in   1   latch flag_in into flags
//   cond_jump    in   3   branch condition select
//   uncond_jump  in   1   PC-relative unconditional jump
//   jump_reg     in   1   absolute jump to rs_val (word aligned)
//   offset       in  16   signed word offset for relative targets
//   rs_val       in  32   register jump target
//   pc           out 32   current instruction address
//   link_pc      out 32   return address of the last taken redirect
//   flags        out  3   registered flag state
//   taken        out  1   high the cycle after a taken redirect
//   flush        out  1   high the cycle after a taken redirect
//   running      out  1   high while in RUN
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt,
   input  logic        step,
   input  logic [2:0]  flag_in,
   input  logic        flag_we,
   input  logic [2:0]  cond_jump,
   input  logic        uncond_jump,
   input  logic        jump_reg,
   input  logic [15:0] offset,
   input  logic [31:0] rs_val,
   output logic [31:0] pc,
   output logic [31:0] link_pc,
   output logic [2:0]  flags,
   output logic        taken,
   output logic        flush,
   output logic        running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state;

   logic        cond_true;
   logic        redirect;
   logic [31:0] seq_pc;
   logic [31:0] rel_pc;
   logic [31:0] next_pc;

   // Branch condition from the registered flags; codes 110/111 never taken.
   function automatic logic cond_eval(input logic [2:0] code, input logic [2:0] f);
      logic res;
      case (code)
         3'b001:  res = f[2];    // bltz : sign
         3'b010:  res = f[1];    // bz   : zero
         3'b011:  res = ~f[1];   // bnz  : !zero
         3'b100:  res = f[0];    // bcy  : carry
         3'b101:  res = ~f[0];   // bncy : !carry
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Relative target: word offset sign-extended and scaled to bytes, mod 2^32.
   function automatic logic [31:0] rel_target(input logic [31:0] base,
                                              input logic [15:0] off);
      logic signed [31:0] disp;
      disp = {{14{off[15]}}, off, 2'b00};
      return base + $unsigned(disp);
   endfunction

   always_comb begin
      cond_true = cond_eval(cond_jump, flags);
      seq_pc    = pc + 32'd4;
      rel_pc    = rel_target(pc, offset);
      redirect  = jump_reg | uncond_jump | cond_true;
      if (jump_reg)
         next_pc = rs_val & ~32'h0000_0003;
      else if (uncond_jump || cond_true)
         next_pc = rel_pc;
      else
         next_pc = seq_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         link_pc <= 32'h0000_0000;
         flags   <= 3'b000;
         taken   <= 1'b0;
         flush   <= 1'b0;
      end else begin
         // taken/flush are single-cycle pulses unless re-armed by another
         // taken step, which keeps them high back to back.
         taken <= 1'b0;
         flush <= 1'b0;
         case (state)
            IDLE: begin
               if (start)
                  state <= RUN;
            end
            RUN: begin
               if (step) begin
                  pc <= next_pc;
                  if (redirect) begin
                     link_pc <= seq_pc;
                     taken   <= 1'b1;
                     flush   <= 1'b1;
                  end
               end
               // Branch above already sampled the old flags this cycle.
               if (flag_we)
                  flags <= flag_in;
               // A coincident step has been applied; HALT takes effect after.
               if (halt)
                  state <= HALT;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign running = (state == RUN);

endmodule
